// File: rtl/mod_sched_pkg.sv
// Shared encodings and widths for the mod engine job scheduler.
package mod_sched_pkg;

    localparam int DC_W  = 24;
    localparam int CAP_W = 8;

    localparam int CAP_DECODE = 6;
    localparam int CAP_ENCODE = 5;
    localparam int CAP_MEMCPY = 4;
    localparam int CAP_RABIN  = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RST   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CHECK = S_CHECK,
        ST_RST   = S_RST,
        ST_RUN   = S_RUN,
        ST_FIN   = S_FIN
    } state_t;

    // A job is runnable only if every capability it needs is present on the engine.
    function automatic logic cap_ok(input logic [CAP_W-1:0] need, input logic [CAP_W-1:0] have);
        return (need & ~have) == '0;
    endfunction

endpackage

// File: rtl/mod_sched_rr_arb.sv
// Combinational round-robin pick: first requester above ptr_i, wrapping.
module mod_rr_arb
    import mod_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CHW-1:0] ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CHW-1:0] idx_o,
    output logic           any_o
);

    int c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int i = 1; i <= NCH; i++) begin
            c = (int'(ptr_i) + i) % NCH;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                idx_o    = CHW'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_sched.sv
// Job scheduler for the single rabin64 mod engine: arbitrates channels,
// checks capabilities, sequences engine reset/run and reports completion.
//
// state | meaning
// IDLE  | engine held in reset, waiting for a request
// CHECK | owner latched, capability mask tested
// RST   | engine reset held for RST_CYCLES cycles
// RUN   | engine enabled, waiting for m_endn / abort / watchdog
// FIN   | done (and error) pulse to owner, release grant
module mod_sched
    import mod_sched_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int RST_CYCLES = 4,
    parameter int TO_W       = 20
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH*DC_W-1:0]  ch_dc,
    input  logic [NCH*CAP_W-1:0] ch_capreq,
    output logic [NCH-1:0]       ch_gnt,
    output logic [NCH-1:0]       ch_done,
    output logic [NCH-1:0]       ch_err,
    output logic [CHW-1:0]       ch_sel,
    output logic                 busy,
    output logic                 m_reset,
    output logic                 m_enable,
    output logic [DC_W-1:0]      dc,
    input  logic                 m_endn,
    input  logic [CAP_W-1:0]     m_cap
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t             state_q, state_d;
    logic [CHW-1:0]     sel_q, sel_d;
    logic [CHW-1:0]     rr_q, rr_d;
    logic [NCH-1:0]     gnt_q, gnt_d;
    logic [NCH-1:0]     done_q, done_d;
    logic [NCH-1:0]     err_q, err_d;
    logic [DC_W-1:0]    dc_q, dc_d;
    logic [CAP_W-1:0]   capreq_q, capreq_d;
    logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]    wdog_q, wdog_d;
    logic               busy_q, m_reset_q, m_enable_q;

    logic [NCH-1:0]     arb_gnt;
    logic [CHW-1:0]     arb_idx;
    logic               arb_any;

    mod_rr_arb #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req_i (ch_req),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        dc_d     = dc_q;
        capreq_d = capreq_q;
        rst_cnt_d = rst_cnt_q;
        wdog_d   = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    sel_d    = arb_idx;
                    gnt_d    = arb_gnt;
                    dc_d     = ch_dc[DC_W*arb_idx +: DC_W];
                    capreq_d = ch_capreq[CAP_W*arb_idx +: CAP_W];
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!cap_ok(capreq_q, m_cap)) begin
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    rr_d    = sel_q;
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = RCW'(RST_CYCLES - 1);
                    state_d   = ST_RST;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == '0) begin
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RCW'(1);
                end
            end
            ST_RUN: begin
                wdog_d = wdog_q + TO_W'(1);
                // End beats abort beats timeout; the last two both flag an error.
                if (!m_endn) begin
                    done_d  = gnt_q;
                    state_d = ST_FIN;
                end else if (!ch_req[sel_q] || wdog_q == WD_LAST) begin
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                gnt_d   = '0;
                rr_d    = sel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_q       <= CHW'(NCH - 1);
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            dc_q       <= '0;
            capreq_q   <= '0;
            rst_cnt_q  <= '0;
            wdog_q     <= '0;
            busy_q     <= 1'b0;
            m_reset_q  <= 1'b1;
            m_enable_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dc_q       <= dc_d;
            capreq_q   <= capreq_d;
            rst_cnt_q  <= rst_cnt_d;
            wdog_q     <= wdog_d;
            busy_q     <= (state_d != ST_IDLE);
            m_reset_q  <= (state_d != ST_RUN);
            m_enable_q <= (state_d == ST_RUN);
        end
    end

    assign ch_gnt   = gnt_q;
    assign ch_done  = done_q;
    assign ch_err   = err_q;
    assign ch_sel   = sel_q;
    assign busy     = busy_q;
    assign m_reset  = m_reset_q;
    assign m_enable = m_enable_q;
    assign dc       = dc_q;

endmodule

// File: tb/tb_mod_sched.sv
// Self-checking bench for mod_sched: job table, round robin, abort,
// watchdog timeout and asynchronous reset, with a completion scoreboard.
module tb_mod_sched;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [3:0]  ch_req;
    logic [95:0] ch_dc;
    logic [31:0] ch_capreq;
    logic [3:0]  ch_gnt, ch_done, ch_err;
    logic [1:0]  ch_sel;
    logic        busy, m_reset, m_enable;
    logic [23:0] dc;
    logic        m_endn;
    logic [7:0]  m_cap;

    mod_sched #(.NCH(4), .CHW(2), .RST_CYCLES(4), .TO_W(4)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .ch_req    (ch_req),
        .ch_dc     (ch_dc),
        .ch_capreq (ch_capreq),
        .ch_gnt    (ch_gnt),
        .ch_done   (ch_done),
        .ch_err    (ch_err),
        .ch_sel    (ch_sel),
        .busy      (busy),
        .m_reset   (m_reset),
        .m_enable  (m_enable),
        .dc        (dc),
        .m_endn    (m_endn),
        .m_cap     (m_cap)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        int ch;
        bit err;
    } exp_t;

    typedef struct {
        int          ch;
        logic [23:0] d;
        logic [7:0]  cr;
        logic [7:0]  mc;
        int          run_len;
        logic [3:0]  exp_gnt;
        bit          exp_rej;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: invariants plus scoreboard match of any completion pulse.
    task automatic tick();
        exp_t e;
        @(posedge wb_clk_i);
        #1;
        if (!wb_rst_i) begin
            chk("en_rst_excl", 32'(m_enable & m_reset), 0);
            chk("done_onehot", ($countones(ch_done) <= 1) ? 1 : 0, 1);
            if (ch_done != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: ch_done=%b, expected no pulse", ch_done);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_done", 32'(ch_done), 32'(1) << e.ch);
                    chk("sb_err", 32'(ch_err), e.err ? (32'(1) << e.ch) : 0);
                    chk("sb_sel", 32'(ch_sel), 32'(e.ch));
                end
            end
        end
    endtask

    task automatic wait_gnt();
        int n = 0;
        tick();
        while (ch_gnt == '0 && n < 8) begin
            tick();
            n++;
        end
        chk("gnt_wait", (ch_gnt != '0) ? 1 : 0, 1);
    endtask

    task automatic wait_run();
        int n = 0;
        while (!m_enable && n < 12) begin
            tick();
            n++;
        end
        chk("run_wait", 32'(m_enable), 1);
    endtask

    task automatic end_job();
        m_endn = 1'b0;
        tick();
        m_endn = 1'b1;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        wb_rst_i  = 1'b1;
        ch_req    = '0;
        ch_dc     = '0;
        ch_capreq = '0;
        m_endn    = 1'b1;
        m_cap     = '0;
        #1;
        chk("rst_m_reset", 32'(m_reset), 1);
        chk("rst_m_enable", 32'(m_enable), 0);
        chk("rst_gnt", 32'(ch_gnt), 0);
        chk("rst_done", 32'(ch_done), 0);
        chk("rst_err", 32'(ch_err), 0);
        chk("rst_sel", 32'(ch_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dc", 32'(dc), 0);
        #3;
        wb_rst_i = 1'b0;

        vt[0] = '{0, 24'h00A5C3, 8'h08, 8'h08, 10, 4'b0001, 1'b0};
        vt[1] = '{2, 24'h123456, 8'h40, 8'h08,  0, 4'b0100, 1'b1};
        vt[2] = '{1, 24'hFFFFFF, 8'h78, 8'h78,  1, 4'b0010, 1'b0};
        vt[3] = '{3, 24'h000001, 8'h00, 8'h00,  3, 4'b1000, 1'b0};
        vt[4] = '{3, 24'hABCDEF, 8'h30, 8'h20,  0, 4'b1000, 1'b1};
        vt[5] = '{2, 24'h5A5A5A, 8'h10, 8'hFF, 14, 4'b0100, 1'b0};

        for (int v = 0; v < 6; v++) begin
            ch_dc     = {$urandom, $urandom, $urandom};
            ch_capreq = $urandom;
            ch_dc[vt[v].ch*24 +: 24]    = vt[v].d;
            ch_capreq[vt[v].ch*8 +: 8]  = vt[v].cr;
            m_cap  = vt[v].mc;
            ch_req = vt[v].exp_gnt;
            sbq.push_back('{vt[v].ch, vt[v].exp_rej});
            tick();
            chk("vec_gnt", 32'(ch_gnt), 32'(vt[v].exp_gnt));
            chk("vec_busy", 32'(busy), 1);
            if (vt[v].exp_rej) begin
                tick();
                chk("rej_done", 32'(ch_done), 32'(vt[v].exp_gnt));
                chk("rej_err", 32'(ch_err), 32'(vt[v].exp_gnt));
                chk("rej_no_enable", 32'(m_enable), 0);
                chk("rej_m_reset", 32'(m_reset), 1);
                chk("rej_gnt_clr", 32'(ch_gnt), 0);
                ch_req = '0;
                tick();
                chk("rej_idle_enable", 32'(m_enable), 0);
            end else begin
                m_endn = 1'b0;  // low level before RUN must be ignored
                for (int k = 0; k < 4; k++) begin
                    tick();
                    chk("rst_phase_reset", 32'(m_reset), 1);
                    chk("rst_phase_enable", 32'(m_enable), 0);
                end
                m_endn = 1'b1;
                tick();
                chk("run_enable", 32'(m_enable), 1);
                chk("run_dc", 32'(dc), 32'(vt[v].d));
                ch_dc = ~ch_dc;
                for (int r = 1; r < vt[v].run_len; r++) begin
                    tick();
                    chk("run_hold", 32'(m_enable), 1);
                    chk("run_dc_stable", 32'(dc), 32'(vt[v].d));
                end
                end_job();
                chk("fin_done", 32'(ch_done), 32'(vt[v].exp_gnt));
                chk("fin_err", 32'(ch_err), 0);
                chk("fin_m_reset", 32'(m_reset), 1);
                chk("fin_busy", 32'(busy), 1);
                ch_req = '0;
                tick();
                chk("idle_busy", 32'(busy), 0);
                chk("idle_gnt", 32'(ch_gnt), 0);
            end
        end

        // Round robin from a fresh pointer; every channel keeps requesting.
        wb_rst_i = 1'b1;
        #3;
        wb_rst_i  = 1'b0;
        ch_capreq = '0;
        m_cap     = 8'h08;
        ch_req    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt();
            chk("rr_gnt", 32'(ch_gnt), 32'(1) << order[i]);
            sbq.push_back('{order[i], 1'b0});
            wait_run();
            end_job();
            if (i == 4) ch_req = '0;
        end
        tick();

        // Abort: owner drops its request in RUN cycle 3.
        ch_req = 4'b0010;
        wait_gnt();
        chk("abort_gnt", 32'(ch_gnt), 32'b0010);
        sbq.push_back('{1, 1'b1});
        wait_run();
        tick();
        tick();
        ch_req = '0;
        tick();
        chk("abort_done", 32'(ch_done), 32'b0010);
        chk("abort_err", 32'(ch_err), 32'b0010);
        chk("abort_enable", 32'(m_enable), 0);
        chk("abort_reset", 32'(m_reset), 1);
        tick();

        // Watchdog: 15 RUN cycles, then again with m_endn low on cycle 15.
        for (int t = 0; t < 2; t++) begin
            ch_req = 4'b0001;
            wait_gnt();
            sbq.push_back('{0, (t == 0)});
            wait_run();
            for (int k = 0; k < 14; k++) begin
                tick();
                chk("to_run_hold", 32'(m_enable), 1);
            end
            if (t == 1) m_endn = 1'b0;
            tick();
            m_endn = 1'b1;
            chk("to_done", 32'(ch_done), 32'b0001);
            chk("to_err", 32'(ch_err), (t == 0) ? 32'b0001 : 0);
            chk("to_enable", 32'(m_enable), 0);
            ch_req = '0;
            tick();
        end

        // Asynchronous reset in the middle of a RUN.
        ch_req = 4'b0100;
        wait_gnt();
        wait_run();
        tick();
        tick();
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("arst_enable", 32'(m_enable), 0);
        chk("arst_reset", 32'(m_reset), 1);
        chk("arst_gnt", 32'(ch_gnt), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(ch_done), 0);
        ch_req = 4'b1001;
        tick();
        chk("arst_hold_gnt", 32'(ch_gnt), 0);
        wb_rst_i = 1'b0;
        tick();
        chk("arst_prio", 32'(ch_gnt), 32'b0001);
        sbq.push_back('{0, 1'b0});
        wait_run();
        end_job();
        ch_req = 4'b1000;
        wait_gnt();
        chk("arst_ch3", 32'(ch_gnt), 32'b1000);
        sbq.push_back('{3, 1'b0});
        wait_run();
        end_job();
        ch_req = '0;
        tick();
        tick();

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_sched.md
Name: mod_sched

Overview:
Job scheduler and sequencer for the single mod engine (rabin64 hash datapath).
- Accepts hash jobs (24-bit dc descriptor plus required-capability mask) from NCH requesters.
- Round-robin arbitrates among them, checks the capability mask against the engine's m_cap, and pulses engine reset.
- Runs the engine with m_enable until m_endn, then reports done/error to the owning channel.
- ch_sel steers the external src/dst FIFO mux; that mux lives outside this block.

Parameters:
NCH, 4, number of requesting channels
CHW, 2, width of channel index (log2 NCH)
RST_CYCLES, 4, cycles m_reset is held before each job (>=1)
TO_W, 20, watchdog counter width; timeout after 2^TO_W-1 RUN cycles

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous reset, active-high
ch_req  in  NCH  per-channel job request, level, held until ch_done
ch_dc  in  NCH*24  per-channel descriptor, slice i = [24i+23:24i]
ch_capreq  in  NCH*8  per-channel required capability mask, slice i = [8i+7:8i]
ch_gnt  out  NCH  one-hot owner of the engine, CHECK through FIN
ch_done  out  NCH  one-cycle completion pulse to owner
ch_err  out  NCH  one-cycle error pulse, coincident with ch_done
ch_sel  out  CHW  index of current owner, for FIFO steering
busy  out  1  high whenever state != IDLE
m_reset  out  1  engine reset
m_enable  out  1  engine run enable
dc  out  24  descriptor to engine
m_endn  in  1  engine end, active-low
m_cap  in  8  engine capability vector (bit6 decode, bit5 encode, bit4 memcpy, bit3 rabinpoly)

Behaviour:
- Reset values (async, immediate):
  - m_reset=1; all other outputs 0; state=IDLE.
  - rr pointer = NCH-1, so channel 0 wins first; watchdog=0.
- All outputs are registered.
- FSM states: IDLE, CHECK, RST, RUN, FIN.
- IDLE:
  - m_reset=1, m_enable=0.
  - If any ch_req is set: pick the first requester searching from rr_ptr+1 upward with wrap.
  - Latch ch_sel, ch_gnt, dc=ch_dc[sel] and capreq=ch_capreq[sel]; go to CHECK.
- CHECK (1 cycle):
  - If (capreq & ~m_cap) != 0: pulse ch_done and ch_err for the owner, clear ch_gnt, set rr_ptr=sel, go to IDLE. The engine is never enabled.
  - Else load rst_cnt=RST_CYCLES-1 and go to RST.
- RST:
  - m_reset=1, m_enable=0; rst_cnt decrements each cycle.
  - When rst_cnt==0, go to RUN and clear the watchdog.
- RUN:
  - m_reset=0, m_enable=1; watchdog increments each cycle.
  - m_endn==0 -> FIN, err=0.
  - Watchdog reaches all-ones -> FIN, err=1.
  - ch_req[sel] drops -> FIN, err=1 (abort).
  - Priority when several occur in the same cycle: m_endn, then abort, then timeout.
- FIN (1 cycle):
  - m_enable=0, m_reset=1.
  - Pulse ch_done[sel], and ch_err[sel] if err.
  - Clear ch_gnt; rr_ptr=sel; go to IDLE.
- m_endn is sampled only in RUN; a low level in IDLE/CHECK/RST is ignored.
- dc, ch_sel and capreq are stable from CHECK through FIN. ch_dc changes during a job are ignored.
- Timing:
  - Minimum grant latency: 1 cycle from ch_req to ch_gnt.
  - Engine run starts RST_CYCLES+1 cycles after ch_gnt.
  - ch_done arrives 1 cycle after m_endn is sampled low.
- Back-to-back:
  - If the owner still holds ch_req in the cycle after ch_done, it is treated as a new request.
  - The round-robin search starts after the owner, so another pending channel wins first.
- m_enable and m_reset are never high in the same cycle.
- ch_done is never pulsed to a non-owner.
- At most one ch_done bit is set per cycle.
- wb_rst_i asserted mid-job: everything returns to reset values asynchronously, with no done pulse. Requesters retry.

Decomposition:
- Package mod_sched_pkg holds:
  - the state encoding localparams;
  - capability bit indices CAP_DECODE=6, CAP_ENCODE=5, CAP_MEMCPY=4, CAP_RABIN=3;
  - DC_W=24 and CAP_W=8.
- Sub-module mod_rr_arb: combinational round-robin pick, NCH-wide.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot gnt, encoded index, any.

Test Plan:
- Single job: ch_req[0]=1, dc=0x00A5C3, capreq=0x08, m_cap=0x08.
  - Required: ch_gnt=0001 one cycle later; m_reset high for 4 cycles; m_enable high with dc=0x00A5C3.
  - Drive m_endn=0 after 10 cycles -> ch_done[0] pulse, ch_err=0, busy falls the next cycle.
- Capability reject: ch_req[2]=1, capreq=0x40, m_cap=0x08.
  - Required: ch_done[2] and ch_err[2] pulse 2 cycles after the request; m_enable never rises; m_reset stays 1.
- Round robin: ch_req=1111 held, each job ended by m_endn.
  - Required: grant order 0,1,2,3,0.
  - If channel 1 re-requests immediately after its done, channel 2 is still served next.
- Abort: ch_req[1] drops in RUN cycle 3.
  - Required: next cycle FIN with ch_done[1]=ch_err[1]=1; m_enable=0 and m_reset=1 in the same cycle.
- Timeout: TO_W=4, m_endn held high.
  - Required: after 15 RUN cycles, ch_err pulse. Repeat with m_endn low on exactly cycle 15 -> err=0.
- Async reset mid-RUN: assert wb_rst_i asynchronously.
  - Required: m_enable=0, m_reset=1, ch_gnt=0 with no clock edge; no ch_done.
  - After release, a held ch_req[3] is granted and channel 0 priority is restored.
